mux_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 2:1 mux-with-enable (mux_e) between requesters A and B.

---
 rtl/mux_arbiter.sv | 147 ++++++++++++++
 tb/tb_mux_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux_arbiter
// Brief    : Round-robin arbiter driving a shared 2:1 mux-with-enable, with a
//            break-before-make gap (en=0) around every select change.
//            Optional hold limit enabled by defining MUX_ARB_HOLDLIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
    parameter int GAP_CYCLES = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic en
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_switch = 2'd1;
    localparam logic [1:0] c_st_gnt_a  = 2'd2;
    localparam logic [1:0] c_st_gnt_b  = 2'd3;

    localparam logic [3:0] c_gap_last  = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] c_max_hold  = 4'(MAX_HOLD);
`ifdef MUX_ARB_HOLDLIMIT_EN
    // The first grant cycle is already counted when the grant is issued.
    localparam logic [3:0] c_cnt_grant = 4'd1;
`else
    localparam logic [3:0] c_cnt_grant = 4'd0;
`endif

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_params
        $error("mux_arbiter: GAP_CYCLES must be 1..15 and MAX_HOLD 2..15");
    end

    logic [1:0] r_state;
    logic       r_sel;
    logic       r_en;
    logic       r_gnt_a;
    logic       r_gnt_b;
    logic       r_last;
    logic [3:0] r_cnt;

    logic w_any;
    logic w_tgt;
    logic w_req_sel;
    logic w_req_oth;
    logic w_hold_hit;

    assign w_any     = req_a | req_b;
    assign w_tgt     = (req_a & req_b) ? ~r_last : req_b;
    assign w_req_sel = r_sel ? req_b : req_a;
    assign w_req_oth = r_sel ? req_a : req_b;

`ifdef MUX_ARB_HOLDLIMIT_EN
    assign w_hold_hit = w_req_oth && (r_cnt >= c_max_hold);
`else
    assign w_hold_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_sel   <= 1'b0;
            r_en    <= 1'b0;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        if (w_tgt == r_sel) begin
                            r_state <= r_sel ? c_st_gnt_b : c_st_gnt_a;
                            r_gnt_a <= ~r_sel;
                            r_gnt_b <= r_sel;
                            r_en    <= 1'b1;
                            r_cnt   <= c_cnt_grant;
                        end else begin
                            r_state <= c_st_switch;
                            r_sel   <= w_tgt;
                            r_cnt   <= 4'd0;
                        end
                    end
                end
                c_st_switch: begin
                    if (r_cnt != c_gap_last) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else if (w_req_sel) begin
                        r_state <= r_sel ? c_st_gnt_b : c_st_gnt_a;
                        r_gnt_a <= ~r_sel;
                        r_gnt_b <= r_sel;
                        r_en    <= 1'b1;
                        r_cnt   <= c_cnt_grant;
                    end else if (w_req_oth) begin
                        // Target withdrew; a fresh gap is needed to turn around.
                        r_sel <= ~r_sel;
                        r_cnt <= 4'd0;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_gnt_a, c_st_gnt_b: begin
                    if (w_req_sel && !w_hold_hit) begin
`ifdef MUX_ARB_HOLDLIMIT_EN
                        if (r_cnt != c_max_hold) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
`endif
                    end else begin
                        r_gnt_a <= 1'b0;
                        r_gnt_b <= 1'b0;
                        r_en    <= 1'b0;
                        r_last  <= r_sel;
                        if (w_req_oth) begin
                            r_state <= c_st_switch;
                            r_sel   <= ~r_sel;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_gnt_a <= 1'b0;
                    r_gnt_b <= 1'b0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_a = r_gnt_a;
    assign gnt_b = r_gnt_b;
    assign sel   = r_sel;
    assign en    = r_en;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mux_arbiter
// Brief    : Directed self-checking bench for mux_arbiter (GAP_CYCLES=2,
//            MAX_HOLD=4); hold-limit expectations follow MUX_ARB_HOLDLIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic sel;
    logic en;

    logic [3:0] obs;
    logic       prev_sel;
    int         n_cmp = 0;
    int         n_err = 0;

    // Observation vector: {gnt_a, gnt_b, sel, en}
    assign obs = {gnt_a, gnt_b, sel, en};

    always #5 clk = ~clk;

    mux_arbiter #(
        .GAP_CYCLES(2),
        .MAX_HOLD  (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req_a(req_a),
        .req_b(req_b),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .sel  (sel),
        .en   (en)
    );

    task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // Advance one clock, sample 1 ns later, and check the per-cycle invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sel !== prev_sel) chk("bbm_en_on_sel_change", {3'b000, en}, 4'b0000);
        chk("gnt_exclusive", {3'b000, gnt_a & gnt_b}, 4'b0000);
        prev_sel = sel;
    endtask

    initial begin
        prev_sel = 1'b0;
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;

        // T1: reset state
        #2;
        chk("t1_reset", obs, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_idle_after_reset", obs, 4'b0000);
        end

        // T2: fast path for A
        req_a = 1'b1;
        tick();
        chk("t2_grant_a", obs, 4'b1001);
        tick();
        chk("t2_hold_a", obs, 4'b1001);
        req_a = 1'b0;
        tick();
        chk("t2_release_a", obs, 4'b0000);

        // T3: gap of two cycles before B is granted
        req_b = 1'b1;
        tick();
        chk("t3_switch_1", obs, 4'b0010);
        tick();
        chk("t3_switch_2", obs, 4'b0010);
        tick();
        chk("t3_grant_b", obs, 4'b0111);
        req_b = 1'b0;
        tick();
        chk("t3_release_b_sel_held", obs, 4'b0010);

        // Return the select to A
        req_a = 1'b1;
        tick();
        chk("back_switch_1", obs, 4'b0000);
        tick();
        chk("back_switch_2", obs, 4'b0000);
        tick();
        chk("back_grant_a", obs, 4'b1001);
        req_a = 1'b0;
        tick();
        chk("back_release_a", obs, 4'b0000);

        // T6: B withdraws during SWITCH while A requests
        req_b = 1'b1;
        tick();
        chk("t6_switch_b", obs, 4'b0010);
        req_b = 1'b0;
        req_a = 1'b1;
        tick();
        chk("t6_switch_b_2", obs, 4'b0010);
        tick();
        chk("t6_turnaround", obs, 4'b0000);
        tick();
        chk("t6_turnaround_2", obs, 4'b0000);
        tick();
        chk("t6_grant_a", obs, 4'b1001);

        // T1: reset asserted mid-grant clears outputs without a clock edge
        rst = 1'b1;
        #1;
        chk("t1_reset_mid_grant", obs, 4'b0000);
        req_b = 1'b1;
        tick();
        chk("t1_reset_held", obs, 4'b0000);
        rst = 1'b0;

        // T5: both requesting from reset
        tick();
        chk("t5_first_grant_a", obs, 4'b1001);
`ifdef MUX_ARB_HOLDLIMIT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_a", obs, 4'b1001);
        end
        tick();
        chk("t5_revoke_a", obs, 4'b0010);
        tick();
        chk("t5_gap_b", obs, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold_b", obs, 4'b0111);
        end
        tick();
        chk("t5_revoke_b", obs, 4'b0000);
        tick();
        chk("t5_gap_a", obs, 4'b0000);
        tick();
        chk("t5_regrant_a", obs, 4'b1001);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_no_limit_hold_a", obs, 4'b1001);
        end
`endif

        // T4: round robin A, B, A from reset
        rst = 1'b1;
        #1;
        chk("t4_reset", obs, 4'b0000);
        tick();
        chk("t4_reset_held", obs, 4'b0000);
        rst = 1'b0;
        tick();
        chk("t4_grant_a_first", obs, 4'b1001);
        req_a = 1'b0;
        tick();
        chk("t4_switch_to_b", obs, 4'b0010);
        tick();
        chk("t4_switch_to_b_2", obs, 4'b0010);
        tick();
        chk("t4_grant_b", obs, 4'b0111);
        req_a = 1'b1;
        tick();
        chk("t4_b_not_preempted", obs, 4'b0111);
        req_b = 1'b0;
        tick();
        chk("t4_switch_to_a", obs, 4'b0000);
        req_b = 1'b1;
        tick();
        chk("t4_switch_to_a_2", obs, 4'b0000);
        tick();
        chk("t4_grant_a_again", obs, 4'b1001);
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        chk("t4_final_idle", obs, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
